jacobian_vec_mult: RTL and testbench

- Parametrised fixed-point matrix-vector multiplier for the SCARA controller: computes d_theta = J_inv * d_xy for an N x N inverse-Jacobian.
- Produces saturated small signed joint-step integers for the theta-update stage.
- Uses one time-multiplexed signed multiplier-accumulator instead of per-element floating-point cores.
- Has a start/busy/done handshake and a per-channel saturation flag.

---
 rtl/jacobian_vec_mult.sv | 160 ++++++++++++++++
 tb/tb_jacobian_vec_mult.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jacobian_vec_mult.sv
// Fixed-point N x N matrix-vector multiply (d_theta = J_inv * d_xy) on one shared signed MAC,
// with round-half-up, clamping to OUT_W bits and a start/busy/done handshake.
module jacobian_vec_mult #(
  parameter int N         = 2,
  parameter int COEF_W    = 32,
  parameter int COEF_FRAC = 16,
  parameter int VEC_W     = 14,
  parameter int OUT_W     = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N*N*COEF_W-1:0]    mat_flat,
  input  logic [N*VEC_W-1:0]       vec_flat,
  output logic                     busy,
  output logic                     done,
  output logic [N*OUT_W-1:0]       result_flat,
  output logic [N-1:0]             sat
);

  localparam int PW = COEF_W + VEC_W;
  localparam int AW = PW + $clog2(N) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]        LAST    = IW'(N - 1);
  localparam logic signed [AW-1:0] HALF    = AW'(1) << (COEF_FRAC - 1);
  localparam logic signed [AW-1:0] OUT_MAX = AW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [AW-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, ROUND, FIN} state_t;

  state_t                   state_q, state_d;
  logic [N*N*COEF_W-1:0]    mat_q, mat_d;
  logic [N*VEC_W-1:0]       vec_q, vec_d;
  logic [IW-1:0]            row_q, row_d;
  logic [IW-1:0]            col_q, col_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [N*OUT_W-1:0]       shadow_q, shadow_d;
  logic [N-1:0]             shadow_sat_q, shadow_sat_d;
  logic [N*OUT_W-1:0]       result_q, result_d;
  logic [N-1:0]             sat_q, sat_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic signed [COEF_W-1:0] coef;
  logic signed [VEC_W-1:0]  elem;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     rounded;
  logic [OUT_W-1:0]         clamped;
  logic                     clip;

  // Datapath: operand select, full-precision product, row rounding and clamp.
  always_comb begin
    coef    = mat_q[(int'(row_q) * N + int'(col_q)) * COEF_W +: COEF_W];
    elem    = vec_q[int'(col_q) * VEC_W +: VEC_W];
    prod    = coef * elem;
    rounded = (acc_q + HALF) >>> COEF_FRAC;
    clip    = 1'b0;
    clamped = rounded[OUT_W-1:0];
    if (rounded > OUT_MAX) begin
      clamped = OUT_MAX[OUT_W-1:0];
      clip    = 1'b1;
    end else if (rounded < OUT_MIN) begin
      clamped = OUT_MIN[OUT_W-1:0];
      clip    = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    mat_d        = mat_q;
    vec_d        = vec_q;
    row_d        = row_q;
    col_d        = col_q;
    acc_d        = acc_q;
    shadow_d     = shadow_q;
    shadow_sat_d = shadow_sat_q;
    result_d     = result_q;
    sat_d        = sat_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mat_d   = mat_flat;
          vec_d   = vec_flat;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + AW'(prod);
        if (col_q == LAST) begin
          state_d = ROUND;
        end else begin
          col_d = col_q + IW'(1);
        end
      end
      ROUND: begin
        // Rows land in the shadow buffer so partial results never reach the outputs.
        shadow_d[int'(row_q) * OUT_W +: OUT_W] = clamped;
        shadow_sat_d[row_q]                    = clip;
        if (row_q == LAST) begin
          state_d = FIN;
        end else begin
          row_d   = row_q + IW'(1);
          col_d   = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      FIN: begin
        result_d = shadow_q;
        sat_d    = shadow_sat_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mat_q        <= '0;
      vec_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      acc_q        <= '0;
      shadow_q     <= '0;
      shadow_sat_q <= '0;
      result_q     <= '0;
      sat_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mat_q        <= mat_d;
      vec_q        <= vec_d;
      row_q        <= row_d;
      col_q        <= col_d;
      acc_q        <= acc_d;
      shadow_q     <= shadow_d;
      shadow_sat_q <= shadow_sat_d;
      result_q     <= result_d;
      sat_q        <= sat_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_flat = result_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_jacobian_vec_mult.sv
// Bench for jacobian_vec_mult: N=2 instance checked every cycle against a timing/arithmetic
// model, plus directed literal cases and an N=3 instance.
module tb_jacobian_vec_mult;

  localparam int LAT2 = 7;   // N*(N+1)+1 for N=2
  localparam int LAT3 = 13;  // N*(N+1)+1 for N=3

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         start2 = 1'b0;
  logic [127:0] mat2 = '0;
  logic [27:0]  vec2 = '0;
  logic         busy2, done2;
  logic [17:0]  res2;
  logic [1:0]   sat2;

  logic         start3 = 1'b0;
  logic [287:0] mat3 = '0;
  logic [41:0]  vec3 = '0;
  logic         busy3, done3;
  logic [26:0]  res3;
  logic [2:0]   sat3;

  int tests = 0;
  int fails = 0;

  jacobian_vec_mult #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .mat_flat(mat2), .vec_flat(vec2),
    .busy(busy2), .done(done2), .result_flat(res2), .sat(sat2)
  );

  jacobian_vec_mult #(.N(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .mat_flat(mat3), .vec_flat(vec3),
    .busy(busy3), .done(done3), .result_flat(res3), .sat(sat3)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic: exact integer dot product, round half up, clamp to 9 bits.
  function automatic logic [9:0] ref_elem(input int n, input int i,
                                          input logic [287:0] m, input logic [41:0] v);
    longint acc;
    longint r;
    acc = 0;
    for (int j = 0; j < n; j++)
      acc += longint'($signed(m[(i*n+j)*32 +: 32])) * longint'($signed(v[j*14 +: 14]));
    r = (acc + 32768) >>> 16;
    if (r > 255)  return {1'b1, 9'd255};
    if (r < -256) return {1'b1, 9'h100};
    return {1'b0, r[8:0]};
  endfunction

  function automatic logic [19:0] ref2(input logic [127:0] m, input logic [27:0] v);
    logic [9:0] a, b;
    a = ref_elem(2, 0, 288'(m), 42'(v));
    b = ref_elem(2, 1, 288'(m), 42'(v));
    return {b[9], a[9], b[8:0], a[8:0]};
  endfunction

  function automatic logic [127:0] mk2(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic logic [27:0] mkv2(input int x, input int y);
    return {14'(y), 14'(x)};
  endfunction

  // Transaction-level model of the N=2 instance: an accepted start yields the computed
  // result exactly LAT2 edges later; starts while a run is outstanding are dropped.
  bit          m_busy = 0, m_done = 0, m_pend = 0, chk_on = 0;
  logic [17:0] m_res = '0;
  logic [1:0]  m_sat = '0;
  logic [19:0] m_next = '0;
  int          cyc = 0, m_due = 0;

  initial forever begin
    bit was_busy;
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_busy = 0; m_done = 0; m_pend = 0; m_res = '0; m_sat = '0; cyc = 0;
    end else begin
      was_busy = m_busy;
      cyc++;
      m_done = 0;
      if (m_pend && cyc == m_due) begin
        m_done = 1; m_busy = 0; m_pend = 0;
        m_res = m_next[17:0]; m_sat = m_next[19:18];
      end
      if (start2 && !was_busy) begin
        m_busy = 1; m_pend = 1; m_due = cyc + LAT2;
        m_next = ref2(mat2, vec2);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("cyc busy", busy2, m_busy);
      chk("cyc done", done2, m_done);
      chk("cyc result", res2, m_res);
      chk("cyc sat", sat2, m_sat);
    end
  end

  task automatic launch2(input logic [127:0] m, input logic [27:0] v);
    @(negedge clk);
    mat2 = m; vec2 = v; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  task automatic wait_done2(output int lat);
    lat = 0;
    while (done2 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run2(input string name, input logic [127:0] m, input logic [27:0] v,
                      input int e0, input int e1, input int es);
    int lat;
    launch2(m, v);
    chk({name, " busy rise"}, busy2, 1);
    wait_done2(lat);
    chk({name, " latency"}, lat, LAT2);
    chk({name, " r0"}, $signed(res2[8:0]), e0);
    chk({name, " r1"}, $signed(res2[17:9]), e1);
    chk({name, " sat"}, sat2, es);
    @(posedge clk); #1;
  endtask

  task automatic launch3(input logic [287:0] m, input logic [41:0] v, output int lat);
    @(negedge clk);
    mat3 = m; vec3 = v; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    lat = 0;
    while (done3 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, n_done;
    logic [127:0] ident, mixed;
    logic [287:0] m3;
    logic [41:0]  v3;
    logic [9:0]   e;

    ident = mk2(65536, 0, 0, 65536);
    mixed = mk2(32768, 16384, -16384, 32768);

    repeat (3) @(negedge clk);
    chk("reset busy", busy2, 0);
    chk("reset done", done2, 0);
    chk("reset result", res2, 0);
    chk("reset sat", sat2, 0);
    reset = 1'b1;
    chk_on = 1;

    chk("model pin mixed row1", $signed(ref2(mixed, mkv2(10, 4))) , $signed({2'b00, 9'd0, 9'd6}));
    chk("model pin sat", ref2(mk2(131072, 0, 0, 131072), mkv2(200, -200)), {2'b11, 9'h100, 9'd255});

    run2("identity", ident, mkv2(5, -3), 5, -3, 0);
    run2("mixed", mixed, mkv2(10, 4), 6, 0, 0);
    run2("rounding", mk2(32768, 0, 0, 32768), mkv2(3, -3), 2, -1, 0);
    run2("saturate", mk2(131072, 0, 0, 131072), mkv2(200, -200), 255, -256, 3);

    // Second start two cycles into a run must be dropped.
    launch2(ident, mkv2(7, 8));
    @(negedge clk); @(negedge clk);
    vec2 = mkv2(1, 1); start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done2) n_done++;
    end
    chk("ignored start dones", n_done, 1);
    chk("ignored start r0", $signed(res2[8:0]), 7);
    chk("ignored start r1", $signed(res2[17:9]), 8);

    // Start during the done cycle is accepted.
    launch2(ident, mkv2(1, 2));
    wait_done2(lat);
    chk("b2b first r1", $signed(res2[17:9]), 2);
    mat2 = mixed; vec2 = mkv2(10, 4); start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("b2b busy", busy2, 1);
    wait_done2(lat);
    chk("b2b latency", lat, LAT2);
    chk("b2b r0", $signed(res2[8:0]), 6);
    @(posedge clk); #1;

    // Inputs changed mid-run are not seen.
    launch2(mixed, mkv2(-10, 4));
    repeat (3) @(negedge clk);
    vec2 = mkv2(100, 100); mat2 = '0;
    wait_done2(lat);
    chk("midrun r0", $signed(res2[8:0]), -4);
    chk("midrun r1", $signed(res2[17:9]), 5);
    @(posedge clk); #1;

    // Reset mid-run aborts without a done.
    launch2(ident, mkv2(9, 9));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort busy", busy2, 0);
    chk("abort result", res2, 0);
    chk("abort sat", sat2, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done2) n_done++;
    end
    chk("abort no done", n_done, 0);

    // Randomized traffic, including starts while busy and in the done cycle.
    repeat (400) begin
      @(negedge clk);
      mat2 = mk2(int'($urandom_range(0, 262144)) - 131072, int'($urandom_range(0, 262144)) - 131072,
                 int'($urandom_range(0, 262144)) - 131072, int'($urandom_range(0, 262144)) - 131072);
      if ($urandom_range(0, 1) == 1)
        vec2 = mkv2(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
      else
        vec2 = mkv2(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
      start2 = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    start2 = 1'b0;
    repeat (12) @(negedge clk);

    // N=3 instance.
    m3 = '0;
    for (int i = 0; i < 3; i++) m3[(i*3+i)*32 +: 32] = 32'd65536;
    v3 = {14'd3, 14'd2, 14'd1};
    launch3(m3, v3, lat);
    chk("n3 latency", lat, LAT3);
    chk("n3 r0", $signed(res3[8:0]), 1);
    chk("n3 r1", $signed(res3[17:9]), 2);
    chk("n3 r2", $signed(res3[26:18]), 3);
    chk("n3 sat", sat3, 0);
    @(posedge clk); #1;
    repeat (4) begin
      for (int k = 0; k < 9; k++) m3[k*32 +: 32] = 32'(int'($urandom_range(0, 131072)) - 65536);
      for (int k = 0; k < 3; k++) v3[k*14 +: 14] = 14'(int'($urandom_range(0, 1000)) - 500);
      launch3(m3, v3, lat);
      chk("n3 rnd latency", lat, LAT3);
      for (int i = 0; i < 3; i++) begin
        e = ref_elem(3, i, m3, v3);
        chk("n3 rnd res", res3[i*9 +: 9], e[8:0]);
        chk("n3 rnd sat", sat3[i], e[9]);
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
